uart_tx: RTL and testbench

Serial transmitter that converts a parallel byte into an asynchronous serial frame: one start bit (0), DATA_BITS data bits sent LSB first, and one stop bit (1). It sits at the outbound pin of the board's serial link. It is the transmit end of the same frame format that the serial receiver, built from the D_Flipflop sampling stage, deserialises. Upstream logic hands it bytes through a valid/ready handshake.

---
 rtl/uart_tx_if.sv | 15 +
 rtl/uart_tx.sv | 123 ++++++++++++
 tb/tb_uart_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between upstream logic and the UART transmitter.
//   tx_valid  upstream has a byte to send
//   tx_data   byte to send (DATA_BITS wide), sampled on handshake only
//   tx_ready  transmitter can accept a byte this cycle
// master: upstream producer; slave: the transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per handshake into an asynchronous frame:
// start bit (0), DATA_BITS data bits LSB first, stop bit (1). Each bit lasts
// CLKS_PER_BIT clocks. The line idles high and is driven from a register.
// Ports:
//   clk      system clock, everything on posedge
//   reset    synchronous, active-high
//   s_if     byte handshake (tx_valid/tx_data in, tx_ready out)
//   tx       serial line, idle high
//   tx_busy  high during START/DATA/STOP
//   tx_done  one-cycle pulse in the first IDLE cycle after a frame
module uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  s_if,
  output logic      tx,
  output logic      tx_busy,
  output logic      tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               r_state   = IDLE;
  logic                 r_tx      = 1'b1;
  logic                 r_busy    = 1'b0;
  logic                 r_done    = 1'b0;
  logic [CW-1:0]        r_clk_cnt = '0;
  logic [BW-1:0]        r_bit_cnt = '0;
  logic [DATA_BITS-1:0] r_shift   = '0;

  logic                 w_clk_term;
  logic [DATA_BITS-1:0] w_shift_next;

  assign w_clk_term   = (r_clk_cnt == CLK_LAST);
  assign w_shift_next = r_shift >> 1;

  // Ready is masked by reset directly so it is low during the reset cycles.
  assign s_if.tx_ready = (r_state == IDLE) && !reset;
  assign tx            = r_tx;
  assign tx_busy       = r_busy;
  assign tx_done       = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          // In IDLE with reset low, tx_ready is high, so valid alone means handshake.
          if (s_if.tx_valid) begin
            r_shift   <= s_if.tx_data;
            r_state   <= START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
          end
        end
        START: begin
          if (w_clk_term) begin
            r_clk_cnt <= '0;
            r_state   <= DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_clk_term) begin
            r_clk_cnt <= '0;
            r_shift   <= w_shift_next;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              // Next bit is taken from the post-shift value so tx stays registered.
              r_tx      <= w_shift_next[0];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (w_clk_term) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three instances (N=4/8 bits, N=1/8 bits, N=3/5 bits)
// with a cycle-level frame model and a per-instance scoreboard queue.
module tb_uart_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        v [3];
  logic [15:0] d [3];
  logic [2:0]  tx_o, busy_o, done_o, rdy_o;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(5)) if2 ();

  assign if0.tx_valid = v[0];
  assign if1.tx_valid = v[1];
  assign if2.tx_valid = v[2];
  assign if0.tx_data  = d[0][7:0];
  assign if1.tx_data  = d[1][7:0];
  assign if2.tx_data  = d[2][4:0];
  assign rdy_o[0]     = if0.tx_ready;
  assign rdy_o[1]     = if1.tx_ready;
  assign rdy_o[2]     = if2.tx_ready;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut0 (
    .clk(clk), .reset(reset), .s_if(if0),
    .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
  uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
    .clk(clk), .reset(reset), .s_if(if1),
    .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
  uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(5)) dut2 (
    .clk(clk), .reset(reset), .s_if(if2),
    .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));

  function automatic int np(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int dbp(input int i);
    case (i)
      0:       return 8;
      1:       return 8;
      default: return 5;
    endcase
  endfunction

  // Frame model: spec cycle k after the handshake edge; k=1..N start bit,
  // then DATA_BITS data bits LSB first, then the stop bit.
  function automatic logic exp_bit(input logic [15:0] data, input int db,
                                   input int n, input int k);
    int idx;
    idx = (k - 1) / n;
    if (idx == 0) return 1'b0;
    if (idx <= db) return data[idx-1];
    return 1'b1;
  endfunction

  typedef struct {
    logic [15:0] data;
    int          base;
  } frm_t;

  frm_t        sbq [3][$];
  int          pushes [3];
  int          dones_seen [3];
  logic [15:0] rx_bits [3];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int i, input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got=%b exp=%b", nm, i, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic mon(input int i);
    int   n, db, k, flen, idx;
    logic act, e_tx, e_done, e_ready;
    logic [15:0] mask;
    frm_t f;
    n = np(i);
    db = dbp(i);
    flen = (db + 2) * n;
    mask = 16'((32'd1 << db) - 1);
    act = 1'b0;
    e_done = 1'b0;
    e_tx = 1'b1;
    if (sbq[i].size() > 0) begin
      k = cyc - sbq[i][0].base;
      if (k >= 1 && k <= flen) begin
        act = 1'b1;
        e_tx = exp_bit(sbq[i][0].data, db, n, k);
        idx = (k - 1) / n;
        if ((k - 1) % n == 0 && idx >= 1 && idx <= db) rx_bits[i][idx-1] = tx_o[i];
      end else if (k == flen + 1) begin
        e_done = 1'b1;
      end
    end
    e_ready = !reset && !act;
    chk(i, "tx", tx_o[i], e_tx);
    chk(i, "tx_busy", busy_o[i], act);
    chk(i, "tx_done", done_o[i], e_done);
    chk(i, "tx_ready", rdy_o[i], e_ready);
    if (done_o[i]) dones_seen[i]++;
    if (e_done) begin
      f = sbq[i].pop_front();
      chk_int($sformatf("rx_byte[%0d]", i), int'(rx_bits[i] & mask), int'(f.data));
    end
    if (reset) sbq[i].delete();
    if (v[i] && e_ready) begin
      f.data = d[i] & mask;
      f.base = cyc;
      sbq[i].push_back(f);
      rx_bits[i] = '0;
      pushes[i]++;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic send(input int i, input logic [15:0] data, input bit keep);
    int p0;
    int t;
    p0 = pushes[i];
    t = 0;
    v[i] = 1'b1;
    d[i] = data;
    while (pushes[i] == p0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (pushes[i] == p0) begin
      errors++;
      $display("FAIL handshake_timeout[%0d] got=none exp=handshake", i);
    end
    if (!keep) v[i] = 1'b0;
    d[i] = 16'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk_int("idle_timeout", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dn, p;
    for (int i = 0; i < 3; i++) begin
      pushes[i] = 0;
      dones_seen[i] = 0;
      rx_bits[i] = '0;
      v[i] = 1'b1;
      d[i] = 16'($urandom);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_int("no_frame_after_reset", pushes[0] + pushes[1] + pushes[2], 0);

    send(0, 16'hA5, 1'b0);
    wait_idle();

    dn = dones_seen[0];
    send(0, 16'h00, 1'b1);
    send(0, 16'hFF, 1'b0);
    wait_idle();
    chk_int("b2b_dones", dones_seen[0] - dn, 2);

    dn = dones_seen[0];
    p = pushes[0];
    send(0, 16'hA5, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    v[0] = 1'b1;
    d[0] = 16'h3C;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    d[0] = 16'($urandom);
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk_int("ignored_pushes", pushes[0] - p, 1);
    chk_int("ignored_dones", dones_seen[0] - dn, 1);

    dn = dones_seen[0];
    send(0, 16'hA5, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk_int("abort_no_done", dones_seen[0] - dn, 0);
    send(0, 16'h81, 1'b0);
    wait_idle();
    chk_int("after_abort_done", dones_seen[0] - dn, 1);

    fork
      send(1, 16'h5A, 1'b0);
      send(2, 16'h13, 1'b0);
    join
    wait_idle();

    fork
      for (int i = 0; i < 3; i++) begin
        automatic int ii = i;
        fork
          begin
            for (int j = 0; j < 15; j++) begin
              automatic int g = $urandom_range(0, 4);
              send(ii, 16'($urandom), (g == 0) && (j < 14));
              repeat (g) @(posedge clk);
              if (g > 0) #1;
            end
          end
        join_none
      end
    join
    wait fork;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
